// File: rtl/axil_csr_master.sv
// axil_csr_master: single-outstanding AXI4-Lite initiator that turns CSR commands into read/write
// transactions, with a response timeout that drains any late beat before accepting new work.
module axil_csr_master #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_address,
    input  logic [DATA_WIDTH-1:0]     cmd_write_data,
    input  logic [DATA_WIDTH/8-1:0]   cmd_strobe,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_read_data,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic                      AXIL_awvalid,
    input  logic                      AXIL_awready,
    output logic [ADDRESS_WIDTH-1:0]  AXIL_awaddr,
    output logic [2:0]                AXIL_awprot,
    output logic                      AXIL_wvalid,
    input  logic                      AXIL_wready,
    output logic [DATA_WIDTH-1:0]     AXIL_wdata,
    output logic [DATA_WIDTH/8-1:0]   AXIL_wstrb,
    input  logic                      AXIL_bvalid,
    output logic                      AXIL_bready,
    input  logic [1:0]                AXIL_bresp,
    output logic                      AXIL_arvalid,
    input  logic                      AXIL_arready,
    output logic [ADDRESS_WIDTH-1:0]  AXIL_araddr,
    output logic [2:0]                AXIL_arprot,
    input  logic                      AXIL_rvalid,
    output logic                      AXIL_rready,
    input  logic [DATA_WIDTH-1:0]     AXIL_rdata,
    input  logic [1:0]                AXIL_rresp
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {IDLE, WRITE, WRITE_RESP, READ, READ_RESP, RESPOND, DRAIN} state_t;

    state_t                  state, state_n;
    logic                    is_write;
    logic [CW-1:0]           cnt;
    logic                    cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, rsp_fire;
    logic                    resp_fire, limit, enter_rsp;
    logic                    cmd_ready_n, busy_n, awvalid_n, wvalid_n, arvalid_n;
    logic                    bready_n, rready_n, rsp_valid_n, rsp_timeout_n;
    logic [1:0]              rsp_resp_n;
    logic [DATA_WIDTH-1:0]   rsp_read_data_n;

    assign AXIL_awprot = 3'b000;
    assign AXIL_arprot = 3'b000;
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign aw_fire   = AXIL_awvalid & AXIL_awready;
    assign w_fire    = AXIL_wvalid & AXIL_wready;
    assign b_fire    = AXIL_bvalid & AXIL_bready;
    assign ar_fire   = AXIL_arvalid & AXIL_arready;
    assign r_fire    = AXIL_rvalid & AXIL_rready;
    assign rsp_fire  = rsp_valid & rsp_ready;
    assign resp_fire = is_write ? b_fire : r_fire;
    // A real beat in the same cycle as the limit wins over the timeout.
    assign limit     = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            is_write      <= 1'b0;
            cnt           <= '0;
            cmd_ready     <= 1'b0;
            busy          <= 1'b0;
            AXIL_awvalid  <= 1'b0;
            AXIL_wvalid   <= 1'b0;
            AXIL_arvalid  <= 1'b0;
            AXIL_bready   <= 1'b0;
            AXIL_rready   <= 1'b0;
            AXIL_awaddr   <= '0;
            AXIL_araddr   <= '0;
            AXIL_wdata    <= '0;
            AXIL_wstrb    <= '0;
            rsp_valid     <= 1'b0;
            rsp_resp      <= 2'b00;
            rsp_timeout   <= 1'b0;
            rsp_read_data <= '0;
        end else begin
            state         <= state_n;
            cnt           <= (state == WRITE_RESP || state == READ_RESP) ? cnt + CW'(1) : '0;
            cmd_ready     <= cmd_ready_n;
            busy          <= busy_n;
            AXIL_awvalid  <= awvalid_n;
            AXIL_wvalid   <= wvalid_n;
            AXIL_arvalid  <= arvalid_n;
            AXIL_bready   <= bready_n;
            AXIL_rready   <= rready_n;
            rsp_valid     <= rsp_valid_n;
            rsp_resp      <= rsp_resp_n;
            rsp_timeout   <= rsp_timeout_n;
            rsp_read_data <= rsp_read_data_n;
            if (cmd_fire) begin
                is_write    <= cmd_write;
                AXIL_awaddr <= cmd_address;
                AXIL_araddr <= cmd_address;
                AXIL_wdata  <= cmd_write_data;
                AXIL_wstrb  <= cmd_strobe;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = cmd_fire ? (cmd_write ? WRITE : READ) : IDLE;
            WRITE:      state_n = ((~AXIL_awvalid | aw_fire) & (~AXIL_wvalid | w_fire)) ? WRITE_RESP : WRITE;
            WRITE_RESP: state_n = (b_fire | limit) ? RESPOND : WRITE_RESP;
            READ:       state_n = ar_fire ? READ_RESP : READ;
            READ_RESP:  state_n = (r_fire | limit) ? RESPOND : READ_RESP;
            RESPOND:    state_n = rsp_fire ? (rsp_timeout ? DRAIN : IDLE) : RESPOND;
            DRAIN:      state_n = resp_fire ? IDLE : DRAIN;
            default:    state_n = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead from the next state and registered.
    always_comb begin
        enter_rsp       = state_n == RESPOND && state != RESPOND;
        cmd_ready_n     = state_n == IDLE;
        busy_n          = state_n != IDLE;
        awvalid_n       = (cmd_fire & cmd_write) | (AXIL_awvalid & ~AXIL_awready);
        wvalid_n        = (cmd_fire & cmd_write) | (AXIL_wvalid & ~AXIL_wready);
        arvalid_n       = (cmd_fire & ~cmd_write) | (AXIL_arvalid & ~AXIL_arready);
        bready_n        = state_n == WRITE_RESP || (state_n == DRAIN && is_write);
        rready_n        = state_n == READ_RESP || (state_n == DRAIN && !is_write);
        rsp_valid_n     = state_n == RESPOND;
        rsp_timeout_n   = enter_rsp ? ~resp_fire : rsp_timeout;
        rsp_resp_n      = enter_rsp ? (~resp_fire ? 2'b10 : (is_write ? AXIL_bresp : AXIL_rresp)) : rsp_resp;
        rsp_read_data_n = enter_rsp ? (r_fire ? AXIL_rdata : '0) : rsp_read_data;
    end
endmodule

// File: tb/tb_axil_csr_master.sv
// tb_axil_csr_master: scoreboard bench driving commands against a configurable AXI4-Lite slave model.
module tb_axil_csr_master;
    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_address, cmd_write_data;
    logic [3:0]  cmd_strobe;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [31:0] rsp_read_data;
    logic [1:0]  rsp_resp;
    logic        AXIL_awvalid, AXIL_awready, AXIL_wvalid, AXIL_wready;
    logic        AXIL_bvalid, AXIL_bready, AXIL_arvalid, AXIL_arready, AXIL_rvalid, AXIL_rready;
    logic [31:0] AXIL_awaddr, AXIL_araddr, AXIL_wdata, AXIL_rdata;
    logic [3:0]  AXIL_wstrb;
    logic [2:0]  AXIL_awprot, AXIL_arprot;
    logic [1:0]  AXIL_bresp, AXIL_rresp;

    axil_csr_master #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_write_data(cmd_write_data), .cmd_strobe(cmd_strobe),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_read_data(rsp_read_data),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .AXIL_awvalid(AXIL_awvalid), .AXIL_awready(AXIL_awready), .AXIL_awaddr(AXIL_awaddr), .AXIL_awprot(AXIL_awprot),
        .AXIL_wvalid(AXIL_wvalid), .AXIL_wready(AXIL_wready), .AXIL_wdata(AXIL_wdata), .AXIL_wstrb(AXIL_wstrb),
        .AXIL_bvalid(AXIL_bvalid), .AXIL_bready(AXIL_bready), .AXIL_bresp(AXIL_bresp),
        .AXIL_arvalid(AXIL_arvalid), .AXIL_arready(AXIL_arready), .AXIL_araddr(AXIL_araddr), .AXIL_arprot(AXIL_arprot),
        .AXIL_rvalid(AXIL_rvalid), .AXIL_rready(AXIL_rready), .AXIL_rdata(AXIL_rdata), .AXIL_rresp(AXIL_rresp)
    );

    always #5 clock = ~clock;

    typedef struct {logic [31:0] d; logic [1:0] r; logic t;} exp_t;
    exp_t sb[$];
    int n_checks = 0, n_pass = 0, cyc = 0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0, aw_cnt, w_cnt, ar_cnt;
    int aw_beats = 0, w_beats = 0, ar_beats = 0, b_beats = 0, r_beats = 0, ar_cycles = 0;
    bit b_hold = 0, r_hold = 0, aw_got, w_got, b_pend, r_pend, b_fired, r_fired, w_drop = 0;
    logic [31:0] r_data_cfg = '0, seen_awaddr = '0, seen_wdata = '0, seen_araddr = '0;
    logic [1:0]  r_resp_cfg = 2'b00;
    logic [3:0]  seen_wstrb = '0;
    int rr_rise = 0, lat = 0;
    bit rr_q = 0, rv_q = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, want);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] r, input logic t);
        exp_t e;
        e.d = d; e.r = r; e.t = t;
        sb.push_back(e);
    endtask

    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        step();
        cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr; cmd_write_data = data; cmd_strobe = strb;
        do begin
            @(negedge clock);
            n++;
        end while (!cmd_ready && n < 100);
        chk("cmd_accept", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("rsp_outstanding", sb.size(), 0);
        repeat (2) @(negedge clock);
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Slave model: decides readies/valids at the falling edge for the next rising edge.
    initial begin
        AXIL_awready = 0; AXIL_wready = 0; AXIL_arready = 0; AXIL_bvalid = 0; AXIL_rvalid = 0;
        AXIL_bresp = 2'b00; AXIL_rresp = 2'b00; AXIL_rdata = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                AXIL_awready = 0; AXIL_wready = 0; AXIL_arready = 0; AXIL_bvalid = 0; AXIL_rvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_got = 0; w_got = 0;
                b_pend = 0; r_pend = 0; b_fired = 0; r_fired = 0;
            end else begin
                if (b_fired) begin AXIL_bvalid = 0; b_fired = 0; end
                else if (b_pend && !b_hold) begin AXIL_bvalid = 1; b_pend = 0; end
                if (AXIL_bvalid && AXIL_bready) begin b_fired = 1; b_beats++; end
                if (r_fired) begin AXIL_rvalid = 0; r_fired = 0; end
                else if (r_pend && !r_hold) begin
                    AXIL_rvalid = 1; AXIL_rdata = r_data_cfg; AXIL_rresp = r_resp_cfg; r_pend = 0;
                end
                if (AXIL_rvalid && AXIL_rready) begin r_fired = 1; r_beats++; end
                AXIL_awready = AXIL_awvalid && aw_cnt >= aw_wait;
                aw_cnt = (AXIL_awvalid && !AXIL_awready) ? aw_cnt + 1 : 0;
                if (AXIL_awvalid && AXIL_awready) begin aw_beats++; aw_got = 1; seen_awaddr = AXIL_awaddr; end
                AXIL_wready = AXIL_wvalid && w_cnt >= w_wait;
                w_cnt = (AXIL_wvalid && !AXIL_wready) ? w_cnt + 1 : 0;
                if (AXIL_wvalid && AXIL_wready) begin
                    w_beats++; w_got = 1; seen_wdata = AXIL_wdata; seen_wstrb = AXIL_wstrb;
                end
                if (!AXIL_wvalid && AXIL_awvalid) w_drop = 1;
                if (AXIL_arvalid) ar_cycles++;
                AXIL_arready = AXIL_arvalid && ar_cnt >= ar_wait;
                ar_cnt = (AXIL_arvalid && !AXIL_arready) ? ar_cnt + 1 : 0;
                if (AXIL_arvalid && AXIL_arready) begin ar_beats++; r_pend = 1; seen_araddr = AXIL_araddr; end
                if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; end
            end
        end
    end

    // Response monitor: pops the scoreboard on each rsp handshake.
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (!reset) begin
            if (rsp_valid && !rv_q) lat = cyc - rr_rise;
            if (AXIL_rready && !rr_q) rr_rise = cyc;
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_read_data", rsp_read_data, e.d);
                    chk("rsp_resp", rsp_resp, e.r);
                    chk("rsp_timeout", rsp_timeout, e.t);
                end
            end
        end
        rr_q = AXIL_rready;
        rv_q = rsp_valid;
    end

    initial begin
        int a0, w0, b0, r0, n;
        logic [31:0] d0;
        logic [1:0]  p0;
        bit stable;
        reset = 1; rsp_ready = 1; cmd_valid = 0; cmd_write = 0;
        cmd_address = '0; cmd_write_data = '0; cmd_strobe = '0;
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk("rst_ctl", {cmd_ready, busy, rsp_valid, rsp_timeout, rsp_resp, AXIL_awvalid, AXIL_wvalid,
                        AXIL_bready, AXIL_arvalid, AXIL_rready}, 0);
        chk("rst_addr", {AXIL_awaddr, AXIL_araddr}, 0);
        chk("rst_data", {AXIL_wdata, rsp_read_data}, 0);
        @(negedge clock);
        chk("idle_cmd_ready", cmd_ready, 1);

        a0 = aw_beats; w0 = w_beats;
        push(32'h0, 2'b00, 1'b0);
        send(1, 32'h404, 32'hDEADBEEF, 4'hF);
        wait_rsp();
        chk("wr_aw_beats", aw_beats - a0, 1);
        chk("wr_w_beats", w_beats - w0, 1);
        chk("wr_awaddr", seen_awaddr, 32'h404);
        chk("wr_wdata", seen_wdata, 32'hDEADBEEF);
        chk("wr_wstrb", seen_wstrb, 4'hF);

        ar_wait = 3; r_data_cfg = 32'h12345678; r_resp_cfg = 2'b10; ar_cycles = 0;
        push(32'h12345678, 2'b10, 1'b0);
        send(0, 32'h10, 32'h0, 4'h0);
        wait_rsp();
        chk("rd_arvalid_cycles", ar_cycles, 4);
        chk("rd_araddr", seen_araddr, 32'h10);
        ar_wait = 0;

        aw_wait = 5; w_wait = 0; w_drop = 0;
        a0 = aw_beats; w0 = w_beats; b0 = b_beats;
        push(32'h0, 2'b00, 1'b0);
        send(1, 32'h408, 32'hA5A5_0F0F, 4'h3);
        wait_rsp();
        chk("split_w_dropped_first", w_drop, 1);
        chk("split_aw_beats", aw_beats - a0, 1);
        chk("split_w_beats", w_beats - w0, 1);
        chk("split_b_beats", b_beats - b0, 1);
        chk("split_wstrb", seen_wstrb, 4'h3);
        aw_wait = 0;

        r_hold = 1; r_data_cfg = 32'hBAD0BAD0; r_resp_cfg = 2'b00;
        push(32'h0, 2'b10, 1'b1);
        send(0, 32'h20, 32'h0, 4'h0);
        wait_rsp();
        chk("timeout_latency", lat, 9);
        chk("drain_cmd_ready", cmd_ready, 0);
        chk("drain_rready", AXIL_rready, 1);
        chk("drain_busy", busy, 1);
        r0 = r_beats;
        step();
        r_hold = 0;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clock); n++; end
        chk("drain_released", cmd_ready, 1);
        chk("drain_late_r", r_beats - r0, 1);

        step();
        rsp_ready = 0; r_data_cfg = 32'hCAFEF00D; r_resp_cfg = 2'b01;
        push(32'hCAFEF00D, 2'b01, 1'b0);
        send(0, 32'h44, 32'h0, 4'h0);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clock); n++; end
        chk("hold_rsp_valid", rsp_valid, 1);
        d0 = rsp_read_data; p0 = rsp_resp; a0 = aw_beats; stable = 1;
        cmd_valid = 1; cmd_write = 1; cmd_address = 32'h500; cmd_write_data = 32'h1; cmd_strobe = 4'hF;
        repeat (10) begin
            @(negedge clock);
            stable &= rsp_valid && rsp_read_data == d0 && rsp_resp == p0 && !cmd_ready;
        end
        chk("hold_stable", stable, 1);
        chk("hold_data", rsp_read_data, 32'hCAFEF00D);
        chk("hold_no_new_cmd", aw_beats - a0, 0);
        step();
        cmd_valid = 0; rsp_ready = 1;
        wait_rsp();

        step();
        b_hold = 1;
        send(1, 32'h600, 32'h77, 4'hF);
        n = 0;
        while (!AXIL_bready && n < 50) begin @(negedge clock); n++; end
        chk("reset_in_write_resp", AXIL_bready, 1);
        step();
        reset = 1;
        step();
        reset = 0;
        @(negedge clock);
        chk("mid_rst_ctl", {cmd_ready, busy, rsp_valid, rsp_timeout, rsp_resp, AXIL_awvalid, AXIL_wvalid,
                            AXIL_bready, AXIL_arvalid, AXIL_rready}, 0);
        chk("mid_rst_data", {AXIL_wdata, rsp_read_data}, 0);
        b_hold = 0; r_data_cfg = 32'h0F0F0F0F; r_resp_cfg = 2'b00;
        push(32'h0F0F0F0F, 2'b00, 1'b0);
        send(0, 32'h30, 32'h0, 4'h0);
        wait_rsp();
        chk("post_rst_araddr", seen_araddr, 32'h30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axil_csr_master.md
# axil_csr_master

AXI4-Lite initiator that turns single-beat CSR commands into AXI4-Lite read or write transactions. It is the other end of the CSR slave bridge in the shell, and sits wherever on-card logic must reach CSR/RAM space over AXI4-Lite, e.g. self-test, loopback benches, or an on-card sequencer. It handles one outstanding transaction at a time. A response timeout ensures a dead slave cannot hang the command port.

## Interface
- ADDRESS_WIDTH, 32, AXI4-Lite byte address width
- DATA_WIDTH, 32, AXI4-Lite data width (32 only)
- TIMEOUT_CYCLES, 1024, maximum cycles spent waiting for B or R; 0 disables the timeout
- clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_address  in  ADDRESS_WIDTH  byte address
- cmd_write_data  in  DATA_WIDTH  write data
- cmd_strobe  in  DATA_WIDTH/8  write strobes
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_read_data  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  AXI response code (BRESP or RRESP)
- rsp_timeout  out  1  set when the response was produced by the timeout
- busy  out  1  high in every state except IDLE
- AXIL_aw{valid,ready,addr,prot}, AXIL_w{valid,ready,data,strb}, AXIL_b{valid,ready,resp}, AXIL_ar{valid,ready,addr,prot}, AXIL_r{valid,ready,data,resp}: standard AXI4-Lite master directions; prot fields are tied to 3'b000

## Operation
- States are IDLE, WRITE, WRITE_RESP, READ, READ_RESP, RESPOND and DRAIN.
- **IDLE**
  - cmd_ready = 1.
  - On cmd_valid, latch the address, data, strobe and write flag.
  - Go to WRITE if cmd_write = 1, otherwise READ.
- **WRITE**
  - Assert awvalid and wvalid together.
  - Each valid drops independently after its own handshake; ordering between AW and W is unrestricted.
  - Once both handshakes are complete, go to WRITE_RESP.
- **WRITE_RESP**
  - bready = 1.
  - On a B handshake, capture bresp, set rsp_read_data = 0, and go to RESPOND.
- **READ**
  - Assert arvalid until its handshake, then go to READ_RESP.
- **READ_RESP**
  - rready = 1.
  - On an R handshake, capture rdata and rresp, and go to RESPOND.
- **Timeout**
  - The counter clears when WRITE_RESP or READ_RESP is entered and increments every cycle spent in that state.
  - If it reaches TIMEOUT_CYCLES without a handshake, return rsp_resp = 2'b10, rsp_timeout = 1 and rsp_read_data = 0, then go to DRAIN.
  - The timeout does not apply to the WRITE and READ states.
- **RESPOND**
  - rsp_valid = 1; outputs are held stable until rsp_ready.
  - On the handshake, go to IDLE; a timed-out transaction goes to DRAIN instead.
- **DRAIN**
  - Keeps bready or rready (matching the stalled transaction) high until a late B/R handshake arrives.
  - The late response is discarded, then go to IDLE.
  - cmd_ready = 0 throughout.
- **Reset**
  - Reset in any state returns to IDLE.
  - All valids, readies, rsp_* outputs, busy and the counter reset to 0.
  - An in-flight transaction is abandoned without a response.
- All AXI and rsp outputs are registered.

## Timing
- Cycle 0: cmd handshake.
- Cycle 1: awvalid/wvalid (or arvalid) high.
- Against a slave whose ready is always high: B/R arrives at cycle N, rsp_valid is high at cycle N+1, and cmd_ready returns the cycle after the rsp handshake.
- Against the shell CSR slave:
  - Write: rsp_valid at cycle 4.
  - Read: rsp_valid at cycle 5.
- Back-to-back commands: minimum spacing is one IDLE cycle between rsp handshake and the next cmd handshake.
- Timeout: the response appears exactly TIMEOUT_CYCLES+1 cycles after entering the RESP state.
- Simultaneous events: a B/R handshake in the same cycle the counter reaches the limit counts as the real response (rsp_timeout = 0).

## Test plan
- Write 0xDEADBEEF to 0x404 with strobe 0xF, slave responds with zero delay → exactly one AW and one W beat, awaddr = 0x404, rsp_resp = 0, rsp_timeout = 0, rsp_read_data = 0.
- Read 0x10, slave returns 0x12345678 with rresp = 2'b10 after a 3-cycle arready delay → arvalid held for 4 cycles, rsp_read_data = 0x12345678, rsp_resp = 2'b10.
- Write where wready arrives 5 cycles before awready → wvalid drops after its handshake while awvalid stays high; exactly one write completes.
- Read with rvalid withheld, TIMEOUT_CYCLES = 8 → rsp_valid 9 cycles after READ_RESP entry with rsp_timeout = 1 and rsp_resp = 2'b10; a late R beat is swallowed in DRAIN; cmd_ready stays 0 until then.
- rsp_ready held low for 10 cycles → rsp_valid, rsp_resp and rsp_read_data stay stable; no new command is accepted.
- Reset asserted while in WRITE_RESP → next cycle all outputs are 0 and the block is in IDLE; a following read completes normally.
